fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_pkg.sv | 9 +
 rtl/fp_norm_round.sv | 36 +++
 rtl/fp_mul_seq.sv | 87 ++++++++
 tb/tb_fp_mul_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and FSM state type for the sequential FP multiplier
package fp_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W = 8;
  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;
  localparam int EXPS_W = 10;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalize a 48-bit mantissa product, optionally round (FP_MUL_ROUND_EN), pack with range flags
module fp_norm_round
  import fp_pkg::*;
(
  input  logic [PROD_W-1:0]        prod,
  input  logic signed [EXPS_W-1:0] exp_in,
  input  logic                     sign,
  input  logic                     zero,
  output logic [31:0]              result,
  output logic                     overflow,
  output logic                     underflow
);
`ifdef FP_MUL_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  logic hi, guard, sticky, rnd;
  logic [22:0] frac;
  logic [23:0] frac_r;
  logic signed [EXPS_W-1:0] exp_f;
  always_comb begin
    hi = prod[47];
    frac = hi ? prod[46:24] : prod[45:23];
    guard = hi ? prod[23] : prod[22];
    sticky = hi ? |prod[22:0] : |prod[21:0];
    rnd = ROUND & guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + 24'(rnd);
    // a rounding carry leaves frac_r[22:0] at zero, so only the exponent moves
    exp_f = exp_in + EXPS_W'(hi) + EXPS_W'(frac_r[23]);
    overflow = !zero && exp_f >= 10'sd255;
    underflow = !zero && exp_f <= 10'sd0;
    result = (zero || underflow) ? {sign, 31'b0} :
             overflow ? {sign, 8'hFF, 23'b0} : {sign, exp_f[7:0], frac_r[22:0]};
  end
endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single multiplier, 24-cycle shift-add mantissa product.
// Rounding mode selected by macro FP_MUL_ROUND_EN (nearest-even) else truncation.
module fp_mul_seq #(
  parameter int EXP_BIAS = fp_pkg::EXP_BIAS,
  parameter int MANT_W = fp_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Signo_A,
  input  logic              Signo_B,
  input  logic [7:0]        Exponente_A,
  input  logic [7:0]        Exponente_B,
  input  logic [MANT_W-1:0] Mantissa_A,
  input  logic [MANT_W-1:0] Mantissa_B,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       Result,
  output logic              Overflow,
  output logic              Underflow
);
  import fp_pkg::*;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [MANT_W-1:0] mant_a;
  logic [2*MANT_W-1:0] prod;
  logic signed [EXPS_W-1:0] exp_r;
  logic sign_r, zero_r;
  logic [MANT_W:0] acc;
  logic [31:0] res_n;
  logic ovf_n, unf_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (Start) state_n = MUL;
      MUL: if (cnt == 5'd23) state_n = NORM;
      NORM: state_n = DONE;
      default: state_n = IDLE;
    endcase
    Busy = state == MUL || state == NORM;
    Done = state == DONE;
    // multiplier B sits in the low half and is consumed LSB first
    acc = {1'b0, prod[2*MANT_W-1:MANT_W]} + {1'b0, prod[0] ? mant_a : {MANT_W{1'b0}}};
  end
  fp_norm_round u_norm (
    .prod(prod),
    .exp_in(exp_r),
    .sign(sign_r),
    .zero(zero_r),
    .result(res_n),
    .overflow(ovf_n),
    .underflow(unf_n)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mant_a <= '0;
      prod <= '0;
      exp_r <= '0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      Result <= '0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && Start) begin
        cnt <= '0;
        mant_a <= Mantissa_A;
        prod <= {{MANT_W{1'b0}}, Mantissa_B};
        exp_r <= {2'b0, Exponente_A} + {2'b0, Exponente_B} - EXPS_W'(EXP_BIAS);
        sign_r <= Signo_A ^ Signo_B;
        zero_r <= Exponente_A == 8'd0 || Exponente_B == 8'd0;
      end
      if (state == MUL) begin
        cnt <= cnt + 5'd1;
        prod <= {acc, prod[MANT_W-1:1]};
      end
      if (state == NORM) begin
        Result <= res_n;
        Overflow <= ovf_n;
        Underflow <= unf_n;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: scoreboard bench for fp_mul_seq; driver queues expectations, monitor checks on Done
module tb_fp_mul_seq;
  logic clk = 1'b0;
  logic rst, Start, Signo_A, Signo_B, Busy, Done, Overflow, Underflow;
  logic [7:0] Exponente_A, Exponente_B;
  logic [23:0] Mantissa_A, Mantissa_B;
  logic [31:0] Result;
  typedef struct {
    logic [31:0] r;
    logic ovf;
    logic unf;
    int t0;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  fp_mul_seq dut (
    .clk(clk), .rst(rst), .Start(Start),
    .Signo_A(Signo_A), .Signo_B(Signo_B),
    .Exponente_A(Exponente_A), .Exponente_B(Exponente_B),
    .Mantissa_A(Mantissa_A), .Mantissa_B(Mantissa_B),
    .Busy(Busy), .Done(Done), .Result(Result),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (Done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got Result %h with nothing outstanding", Result);
      end else begin
        e = q.pop_front();
        check("result", Result, e.r);
        check("overflow", 32'(Overflow), 32'(e.ovf));
        check("underflow", 32'(Underflow), 32'(e.unf));
        check("latency", 32'(cyc - e.t0), 32'd25);
      end
    end
  end

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    Signo_A = a[31];
    Exponente_A = a[30:23];
    Mantissa_A = {|a[30:23], a[22:0]};
    Signo_B = b[31];
    Exponente_B = b[30:23];
    Mantissa_B = {|b[30:23], b[22:0]};
  endtask

  task automatic start_only(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    apply(a, b);
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    apply(32'hFFFF_FFFF, 32'h1234_5678);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic ovf, input logic unf);
    start_only(a, b);
    q.push_back('{r, ovf, unf, cyc});
    check("busy", 32'(Busy), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, 32'(Busy), 32'd0);
    check({name, "_done"}, 32'(Done), 32'd0);
    check({name, "_result"}, Result, 32'd0);
    check({name, "_ovf"}, 32'(Overflow), 32'd0);
    check({name, "_unf"}, 32'(Underflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    Start = 1'b0;
    apply(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    issue(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    drain();
    issue(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0);
    drain();
    issue(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0);
    drain();
    issue(32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 1'b0, 1'b0);
    drain();
    issue(32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1'b0, 1'b0);
    drain();
    issue(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1);
    drain();
    issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0);
    drain();
`ifdef FP_MUL_ROUND_EN
    issue(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 1'b0, 1'b0);
`else
    issue(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, 1'b0, 1'b0);
`endif
    drain();

    // second Start while busy must be dropped
    issue(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    apply(32'h4000_0000, 32'h4000_0000);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    drain();
    repeat (30) @(negedge clk);
    check("idle_after_ignored_start", 32'(Busy), 32'd0);

    // abort mid-operation
    start_only(32'h3FC0_0000, 32'h4000_0000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(negedge clk);

    // reset wins over a simultaneous Start
    @(negedge clk);
    apply(32'h3FC0_0000, 32'h4000_0000);
    rst = 1'b1;
    Start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    Start = 1'b0;
    check("rst_start_busy", 32'(Busy), 32'd0);
    @(posedge clk);
    #1;
    check("rst_start_busy_later", 32'(Busy), 32'd0);

    issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
